// File: rtl/csa_pkg.sv
// csa_pkg: FSM state type and default operand/guard widths for the carry-save accumulator
package csa_pkg;
    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_GUARD = 4;
endpackage

// File: rtl/ripple_carry_adder_n.sv
// ripple_carry_adder_n: WIDTH-bit ripple adder (a, b, cin in; sum, cout out)
module ripple_carry_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic carry;
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end
endmodule

// File: rtl/carry_save_accumulator.sv
// carry_save_accumulator: packet summer with carry-save state, one-cycle resolve and valid/ready result port
module carry_save_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GUARD = DEF_GUARD,
    parameter int ACC_W = WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [GUARD:0]   out_count,
    output logic             out_ovf
);
    localparam logic [GUARD:0] OVF_LIM = {1'b1, {GUARD{1'b0}}};
    state_t           state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d, x, maj, rca_sum;
    logic [GUARD:0]   count_q, count_d, count_inc, out_count_q, out_count_d;
    logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;
    logic             accept, take, unused_cout;
    ripple_carry_adder_n #(.WIDTH(ACC_W)) u_rca (
        .a   (s_q),
        .b   (c_q),
        .cin (1'b0),
        .sum (rca_sum),
        .cout(unused_cout)
    );
    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign out_sum   = sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    always_comb begin
        x           = {{GUARD{1'b0}}, in_data};
        maj         = (s_q & c_q) | (s_q & x) | (c_q & x);
        count_inc   = (count_q == '1) ? count_q : count_q + 1'b1;
        s_d         = take ? '0 : accept ? s_q ^ c_q ^ x : s_q;
        c_d         = take ? '0 : accept ? maj << 1 : c_q;
        count_d     = take ? '0 : accept ? count_inc : count_q;
        ovf_d       = take ? 1'b0 : accept ? ovf_q | (count_inc > OVF_LIM) : ovf_q;
        state_d     = (state_q == ACCUM)   ? ((accept && in_last) ? RESOLVE : ACCUM) :
                      (state_q == RESOLVE) ? DONE :
                      (take ? ACCUM : DONE);
        sum_d       = (state_q == RESOLVE) ? rca_sum : sum_q;
        out_count_d = (state_q == RESOLVE) ? count_q : out_count_q;
        out_ovf_d   = (state_q == RESOLVE) ? ovf_q : out_ovf_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_carry_save_accumulator.sv
// tb_carry_save_accumulator: directed-vector self-checking bench at WIDTH=4, GUARD=2
module tb_carry_save_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] out_sum;
    logic [2:0] out_count;
    logic       out_ovf;
    int         n_checks = 0;
    int         n_fail = 0;
    carry_save_accumulator #(.WIDTH(4), .GUARD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic send(input logic [3:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        check("in_ready on send", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask
    task automatic result(input string tag, input int es, input int ec, input int eo);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, out_valid, 1);
        check({tag, " sum"}, out_sum, es);
        check({tag, " count"}, out_count, ec);
        check({tag, " ovf"}, out_ovf, eo);
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        send(15, 0); send(15, 0); send(15, 1);
        result("p45", 45, 3, 0);
        for (int i = 0; i < 5; i++) send(15, i == 4);
        result("p75", 11, 5, 1);
        send(1, 1);
        result("ovf cleared", 1, 1, 0);
        send(9, 1);
        @(negedge clk);
        check("lat edge T+1 out_valid", out_valid, 0);
        @(negedge clk);
        check("lat edge T+2 out_valid", out_valid, 1);
        check("lat sum", out_sum, 9);
        check("lat count", out_count, 1);
        @(posedge clk);
        #1;
        check("in_ready after take", in_ready, 1);
        out_ready = 1'b0;
        send(1, 0); send(2, 1);
        result("stall", 3, 2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall out_valid", out_valid, 1);
            check("stall in_ready", in_ready, 0);
            check("stall sum", out_sum, 3);
            check("stall count", out_count, 2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after stall", in_ready, 1);
        send(2, 0); send(3, 1);
        result("after stall", 5, 2, 0);
        send(7, 0); send(7, 0);
        pulse_rst();
        send(1, 1);
        result("reset mid-packet", 1, 1, 0);
        out_ready = 1'b0;
        send(5, 1);
        result("pre reset done", 5, 1, 0);
        pulse_rst();
        @(negedge clk);
        check("reset in DONE out_valid", out_valid, 0);
        check("reset in DONE in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(4, 1);
        result("after DONE reset", 4, 1, 0);
        send(3, 0);
        repeat (2) @(posedge clk);
        #1;
        send(4, 1);
        result("gaps", 7, 2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
